// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field constants, exception codes and
// the exception controller state encoding.
package cpu_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;

   localparam logic [4:0] EXC_INT = 5'd0;
   localparam logic [4:0] EXC_RI  = 5'd10;
   localparam logic [4:0] EXC_OV  = 5'd12;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_TAKE    = 2'd1,
      ST_HANDLER = 2'd2,
      ST_RETURN  = 2'd3
   } exc_state_e;

   // Fixed priority: overflow beats illegal instruction beats interrupt.
   function automatic logic [4:0] selectExcCode(input logic ovfHit, input logic riHit);
      if (ovfHit) begin
         return EXC_OV;
      end else if (riHit) begin
         return EXC_RI;
      end
      return EXC_INT;
   endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// Bus between the CPU datapath/control unit (master) and the exception
// controller (slave).
interface exc_ctrl_if #(
   parameter int WIDTH   = 32,
   parameter int NUM_IRQ = 4
);
   logic [WIDTH-1:0]     in1;
   logic [WIDTH-1:0]     in2;
   logic [WIDTH-1:0]     result;
   logic [5:0]           opcode;
   logic [5:0]           funct;
   logic                 check_en;
   logic                 illegal_instr;
   logic [WIDTH-1:0]     pc_in;
   logic [NUM_IRQ-1:0]   irq;
   logic [NUM_IRQ-1:0]   irq_mask;
   logic                 eret;
   logic                 ovf;
   logic                 exc_req;
   logic [WIDTH-1:0]     exc_pc;
   logic                 ret_req;
   logic [WIDTH-1:0]     epc;
   logic [NUM_IRQ+4:0]   cause;
   logic                 in_handler;

   modport master (
      output in1, in2, result, opcode, funct, check_en, illegal_instr,
             pc_in, irq, irq_mask, eret,
      input  ovf, exc_req, exc_pc, ret_req, epc, cause, in_handler
   );

   modport slave (
      input  in1, in2, result, opcode, funct, check_en, illegal_instr,
             pc_in, irq, irq_mask, eret,
      output ovf, exc_req, exc_pc, ret_req, epc, cause, in_handler
   );

endinterface

// File: rtl/exc_ctrl_ovf_detect.sv
// Signed overflow detection for add, sub and addi. Only the operand and
// result sign bits decide overflow; unsigned variants never overflow.
module ovf_detect
   import cpu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] in1_i,
   input  logic [WIDTH-1:0] in2_i,
   input  logic [WIDTH-1:0] result_i,
   input  logic [5:0]       opcode_i,
   input  logic [5:0]       funct_i,
   output logic             ovf_o
);

   logic signA;
   logic signB;
   logic signR;
   logic unusedLowBits;

   assign signA = in1_i[WIDTH-1];
   assign signB = in2_i[WIDTH-1];
   assign signR = result_i[WIDTH-1];

   assign unusedLowBits = ^{in1_i[WIDTH-2:0], in2_i[WIDTH-2:0], result_i[WIDTH-2:0]};

   // Add overflows when like-signed operands give a differently signed result;
   // sub overflows when unlike-signed operands flip the sign of operand A.
   always_comb begin
      ovf_o = 1'b0;
      if (opcode_i == OP_ADDI) begin
         ovf_o = (signA == signB) && (signR != signA);
      end else if (opcode_i == OP_RTYPE) begin
         if (funct_i == FN_ADD) begin
            ovf_o = (signA == signB) && (signR != signA);
         end else if (funct_i == FN_SUB) begin
            ovf_o = (signA != signB) && (signR != signA);
         end
      end
   end

endmodule

// File: rtl/exc_ctrl.sv
// Exception controller: captures overflow, illegal-instruction and interrupt
// events, saves EPC/Cause, and sequences the PC to the handler and back.
module exc_ctrl
   import cpu_pkg::*;
#(
   parameter int               WIDTH        = 32,
   parameter int               NUM_IRQ      = 4,
   parameter logic [WIDTH-1:0] HANDLER_ADDR = WIDTH'(32'h8000_0180)
) (
   input logic       clk,
   input logic       reset,
   exc_ctrl_if.slave bus
);

   localparam int CAUSE_W = 5 + NUM_IRQ;

   exc_state_e         state_q;
   logic [WIDTH-1:0]   epc_q;
   logic [CAUSE_W-1:0] cause_q;
   logic               excReq_q;
   logic               retReq_q;
   logic [WIDTH-1:0]   excPc_q;
   logic               inHandler_q;

   logic               ovfComb;
   logic [NUM_IRQ-1:0] pendIrq;
   logic               ovfHit;
   logic               riHit;
   logic               irqHit;
   logic               anySrc;
   logic [CAUSE_W-1:0] cause_d;

   ovf_detect #(
      .WIDTH(WIDTH)
   ) u_ovf (
      .in1_i    (bus.in1),
      .in2_i    (bus.in2),
      .result_i (bus.result),
      .opcode_i (bus.opcode),
      .funct_i  (bus.funct),
      .ovf_o    (ovfComb)
   );

   assign pendIrq = bus.irq & bus.irq_mask;
   assign ovfHit  = bus.check_en & ovfComb;
   assign riHit   = bus.check_en & bus.illegal_instr;
   assign irqHit  = |pendIrq;
   assign anySrc  = ovfHit | riHit | irqHit;
   assign cause_d = {pendIrq, selectExcCode(ovfHit, riHit)};

   // Exception sequencer: IDLE samples sources, TAKE pulses the handler jump,
   // HANDLER waits for eret with no nesting, RETURN pulses the jump back.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         epc_q       <= '0;
         cause_q     <= '0;
         excReq_q    <= 1'b0;
         retReq_q    <= 1'b0;
         excPc_q     <= '0;
         inHandler_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (anySrc) begin
                  state_q     <= ST_TAKE;
                  excReq_q    <= 1'b1;
                  excPc_q     <= HANDLER_ADDR;
                  inHandler_q <= 1'b1;
                  epc_q       <= bus.pc_in;
                  cause_q     <= cause_d;
               end
            end
            ST_TAKE: begin
               state_q  <= ST_HANDLER;
               excReq_q <= 1'b0;
               excPc_q  <= '0;
            end
            ST_HANDLER: begin
               cause_q[CAUSE_W-1:5] <= pendIrq;
               if (bus.check_en && bus.eret) begin
                  state_q  <= ST_RETURN;
                  retReq_q <= 1'b1;
                  excPc_q  <= epc_q;
               end
            end
            ST_RETURN: begin
               state_q     <= ST_IDLE;
               retReq_q    <= 1'b0;
               excPc_q     <= '0;
               inHandler_q <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.ovf        = ovfComb;
   assign bus.exc_req    = excReq_q;
   assign bus.ret_req    = retReq_q;
   assign bus.exc_pc     = excPc_q;
   assign bus.epc        = epc_q;
   assign bus.cause      = cause_q;
   assign bus.in_handler = inHandler_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// behavioural model of the exception rules.
module tb_exc_ctrl;

   localparam int          NIRQ     = 4;
   localparam logic [31:0] HANDLER  = 32'h8000_0180;

   logic clk;
   logic reset;

   int checks = 0;
   int errors = 0;

   exc_ctrl_if #(.WIDTH(32), .NUM_IRQ(NIRQ)) bus ();
   exc_ctrl_if #(.WIDTH(16), .NUM_IRQ(NIRQ)) bus16 ();

   exc_ctrl #(
      .WIDTH        (32),
      .NUM_IRQ      (NIRQ),
      .HANDLER_ADDR (HANDLER)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   exc_ctrl #(
      .WIDTH        (16),
      .NUM_IRQ      (NIRQ),
      .HANDLER_ADDR (16'h0180)
   ) dut16 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus16.slave)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Model state: whether the CPU is inside the handler, which jump pulse is
   // currently showing, and the saved EPC/Cause.
   bit          mInHandler;
   bit          mExcPulse;
   bit          mRetPulse;
   logic [31:0] mEpc;
   logic [8:0]  mCause;

   // Signed overflow from true integer arithmetic: the exact sum/difference
   // must fit in 32-bit two's complement.
   function automatic bit refOvf(input logic [5:0] opc, input logic [5:0] fn,
                                 input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      longint s;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (opc == 6'h08 || (opc == 6'h00 && fn == 6'h20)) begin
         s = sa + sb;
      end else if (opc == 6'h00 && fn == 6'h22) begin
         s = sa - sb;
      end else begin
         return 1'b0;
      end
      return (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Reference model advances on each rising edge from the inputs seen there.
   always @(posedge clk or posedge reset) begin
      logic [3:0] pend;
      logic [4:0] code;
      bit         src;
      if (reset) begin
         mInHandler = 0;
         mExcPulse  = 0;
         mRetPulse  = 0;
         mEpc       = '0;
         mCause     = '0;
      end else begin
         pend = bus.irq & bus.irq_mask;
         if (mRetPulse) begin
            mRetPulse  = 0;
            mInHandler = 0;
         end else if (mExcPulse) begin
            mExcPulse = 0;
         end else if (mInHandler) begin
            mCause[8:5] = pend;
            if (bus.check_en && bus.eret) mRetPulse = 1;
         end else begin
            src  = 1;
            code = 5'd0;
            if (bus.check_en && refOvf(bus.opcode, bus.funct, bus.in1, bus.in2)) code = 5'd12;
            else if (bus.check_en && bus.illegal_instr) code = 5'd10;
            else if (pend != 4'b0) code = 5'd0;
            else src = 0;
            if (src) begin
               mExcPulse  = 1;
               mInHandler = 1;
               mEpc       = bus.pc_in;
               mCause     = {pend, code};
            end
         end
      end
   end

   // Compare every output against the model on each falling edge.
   always @(negedge clk) begin
      logic [31:0] expPc;
      expPc = mExcPulse ? HANDLER : (mRetPulse ? mEpc : 32'h0);
      checkOutput("ovf", {31'b0, bus.ovf},
                  {31'b0, refOvf(bus.opcode, bus.funct, bus.in1, bus.in2)});
      checkOutput("exc_req", {31'b0, bus.exc_req}, {31'b0, mExcPulse});
      checkOutput("ret_req", {31'b0, bus.ret_req}, {31'b0, mRetPulse});
      checkOutput("exc_pc", bus.exc_pc, expPc);
      checkOutput("epc", bus.epc, mEpc);
      checkOutput("cause", {23'b0, bus.cause}, {23'b0, mCause});
      checkOutput("in_handler", {31'b0, bus.in_handler}, {31'b0, mInHandler});
   end

   // Drive one cycle of inputs just after the rising edge.
   task automatic applyStimulus(input logic [5:0] opc, input logic [5:0] fn,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] res, input logic [31:0] pc,
                                input logic ce, input logic ill, input logic er,
                                input logic [3:0] irqV, input logic [3:0] maskV);
      @(posedge clk);
      #2;
      bus.opcode        = opc;
      bus.funct         = fn;
      bus.in1           = a;
      bus.in2           = b;
      bus.result        = res;
      bus.pc_in         = pc;
      bus.check_en      = ce;
      bus.illegal_instr = ill;
      bus.eret          = er;
      bus.irq           = irqV;
      bus.irq_mask      = maskV;
   endtask

   task automatic idleCycle();
      applyStimulus(6'h00, 6'h00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0);
   endtask

   // From TAKE: enter HANDLER, issue eret, pass RETURN, land in IDLE.
   task automatic finishHandler();
      idleCycle();
      applyStimulus(6'h00, 6'h18, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0);
      idleCycle();
      idleCycle();
   endtask

   task automatic randomCycle();
      logic [5:0]  opc;
      logic [5:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [31:0] edges [5];
      edges[0] = 32'h7FFF_FFFF;
      edges[1] = 32'h8000_0000;
      edges[2] = 32'hFFFF_FFFF;
      edges[3] = 32'h0;
      edges[4] = 32'h1;
      case ($urandom_range(0, 7))
         0, 7: begin opc = 6'h00; fn = 6'h20; end
         1:    begin opc = 6'h00; fn = 6'h22; end
         2:    begin opc = 6'h08; fn = 6'($urandom); end
         3:    begin opc = 6'h00; fn = 6'h21; end
         4:    begin opc = 6'h00; fn = 6'h23; end
         5:    begin opc = 6'h09; fn = 6'($urandom); end
         default: begin opc = 6'($urandom); fn = 6'($urandom); end
      endcase
      a = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
      b = ($urandom_range(0, 2) == 0) ? edges[$urandom_range(0, 4)] : $urandom;
      if (opc == 6'h08 || opc == 6'h09 || (opc == 6'h00 && (fn == 6'h20 || fn == 6'h21)))
         res = a + b;
      else if (opc == 6'h00 && (fn == 6'h22 || fn == 6'h23))
         res = a - b;
      else
         res = $urandom;
      applyStimulus(opc, fn, a, b, res, $urandom, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 4) == 0),
                    ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0, 4'($urandom));
   endtask

   // Directed scenarios followed by randomized traffic.
   initial begin
      reset = 1'b1;
      bus.opcode = '0; bus.funct = '0; bus.in1 = '0; bus.in2 = '0;
      bus.result = '0; bus.pc_in = '0; bus.check_en = 1'b0;
      bus.illegal_instr = 1'b0; bus.eret = 1'b0; bus.irq = '0; bus.irq_mask = '0;
      bus16.opcode = '0; bus16.funct = '0; bus16.in1 = '0; bus16.in2 = '0;
      bus16.result = '0; bus16.pc_in = '0; bus16.check_en = 1'b0;
      bus16.illegal_instr = 1'b0; bus16.eret = 1'b0; bus16.irq = '0; bus16.irq_mask = '0;

      repeat (3) @(posedge clk);
      #3;
      checkOutput("reset exc_req", {31'b0, bus.exc_req}, 32'h0);
      checkOutput("reset epc", bus.epc, 32'h0);
      checkOutput("reset cause", {23'b0, bus.cause}, 32'h0);
      reset = 1'b0;

      $display("[TB] add overflow");
      applyStimulus(6'h00, 6'h20, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 32'h0040_0010,
                    1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
      #1 checkOutput("add ovf", {31'b0, bus.ovf}, 32'h1);
      idleCycle();
      #1;
      checkOutput("add exc_req", {31'b0, bus.exc_req}, 32'h1);
      checkOutput("add exc_pc", bus.exc_pc, 32'h8000_0180);
      checkOutput("add epc", bus.epc, 32'h0040_0010);
      checkOutput("add code", {27'b0, bus.cause[4:0]}, 32'd12);
      checkOutput("add in_handler", {31'b0, bus.in_handler}, 32'h1);
      finishHandler();

      $display("[TB] sub overflow and addu");
      applyStimulus(6'h00, 6'h22, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 32'h0040_0020,
                    1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
      #1 checkOutput("sub ovf", {31'b0, bus.ovf}, 32'h1);
      idleCycle();
      #1 checkOutput("sub exc_req", {31'b0, bus.exc_req}, 32'h1);
      finishHandler();
      applyStimulus(6'h00, 6'h21, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 32'h0040_0030,
                    1'b1, 1'b0, 1'b0, 4'h0, 4'h0);
      #1 checkOutput("addu ovf", {31'b0, bus.ovf}, 32'h0);
      idleCycle();
      #1 checkOutput("addu exc_req", {31'b0, bus.exc_req}, 32'h0);

      $display("[TB] priority and masking");
      applyStimulus(6'h00, 6'h20, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 32'h0040_0034,
                    1'b1, 1'b1, 1'b0, 4'h1, 4'h1);
      idleCycle();
      #1;
      checkOutput("prio code", {27'b0, bus.cause[4:0]}, 32'd12);
      checkOutput("prio pending", {28'b0, bus.cause[8:5]}, 32'h1);
      finishHandler();
      applyStimulus(6'h00, 6'h00, 32'h0, 32'h0, 32'h0, 32'h0040_0038,
                    1'b0, 1'b0, 1'b0, 4'h4, 4'hB);
      idleCycle();
      #1 checkOutput("masked irq", {31'b0, bus.exc_req}, 32'h0);

      $display("[TB] sources ignored in handler");
      applyStimulus(6'h00, 6'h00, 32'h0, 32'h0, 32'h0, 32'h0040_0040,
                    1'b0, 1'b0, 1'b0, 4'h1, 4'h1);
      idleCycle();
      idleCycle();
      applyStimulus(6'h08, 6'h00, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 32'h0040_0099,
                    1'b1, 1'b0, 1'b0, 4'h2, 4'h2);
      #1 checkOutput("handler addi ovf", {31'b0, bus.ovf}, 32'h1);
      idleCycle();
      #1;
      checkOutput("handler exc_req", {31'b0, bus.exc_req}, 32'h0);
      checkOutput("handler epc", bus.epc, 32'h0040_0040);
      checkOutput("handler pending", {28'b0, bus.cause[8:5]}, 32'h2);
      applyStimulus(6'h00, 6'h18, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 4'h0, 4'h0);
      idleCycle();
      #1;
      checkOutput("eret ret_req", {31'b0, bus.ret_req}, 32'h1);
      checkOutput("eret exc_pc", bus.exc_pc, 32'h0040_0040);
      idleCycle();
      #1;
      checkOutput("after ret_req", {31'b0, bus.ret_req}, 32'h0);
      checkOutput("after in_handler", {31'b0, bus.in_handler}, 32'h0);

      $display("[TB] asynchronous reset inside handler");
      applyStimulus(6'h00, 6'h00, 32'h0, 32'h0, 32'h0, 32'h0040_0050,
                    1'b0, 1'b0, 1'b0, 4'h1, 4'h1);
      idleCycle();
      @(posedge clk);
      #1 reset = 1'b1;
      #1;
      checkOutput("async in_handler", {31'b0, bus.in_handler}, 32'h0);
      checkOutput("async epc", bus.epc, 32'h0);
      checkOutput("async cause", {23'b0, bus.cause}, 32'h0);
      checkOutput("async exc_pc", bus.exc_pc, 32'h0);
      @(posedge clk);
      #2 reset = 1'b0;
      applyStimulus(6'h00, 6'h00, 32'h0, 32'h0, 32'h0, 32'h0040_0060,
                    1'b0, 1'b0, 1'b0, 4'h8, 4'h8);
      idleCycle();
      #1;
      checkOutput("post-reset exc_req", {31'b0, bus.exc_req}, 32'h1);
      checkOutput("post-reset epc", bus.epc, 32'h0040_0060);
      finishHandler();

      $display("[TB] 16-bit overflow");
      bus16.opcode = 6'h00; bus16.funct = 6'h20;
      bus16.in1 = 16'h7FFF; bus16.in2 = 16'h0001; bus16.result = 16'h8000;
      #1 checkOutput("w16 add ovf", {31'b0, bus16.ovf}, 32'h1);
      bus16.in1 = 16'h1234; bus16.result = 16'h1235;
      #1 checkOutput("w16 add no ovf", {31'b0, bus16.ovf}, 32'h0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 3000; i++) begin
         randomCycle();
      end
      idleCycle();
      @(posedge clk);
      #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
